// File: rtl/mem_arbiter.sv
// BRAM arbiter between the 6502 core and a single DMA requester.
// The core is held off through READY, which only freezes read cycles, so
// pending core writes drain in STALL before the DMA is granted a bounded
// burst; RESUME re-presents the core's frozen read address before READY
// returns so the held read sees the correct BRAM data.
module mem_arbiter #(
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned MAX_BURST = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_dout,
   input  logic              cpu_rw,
   output logic              cpu_ready,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [7:0]        dma_wdata,
   input  logic              dma_we,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we
);

   typedef enum logic [1:0] {
      ST_CPU,
      ST_STALL,
      ST_DMA,
      ST_RESUME
   } state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST);

   state_t     state;
   logic [7:0] beat_cnt;
   logic [7:0] beat_nxt;

   assign beat_nxt = beat_cnt + 8'd1;

   // READY and grant are plain decodes of the registered state, so READY
   // cannot glitch; the grant is qualified by the live request.
   assign cpu_ready = (state == ST_CPU);
   assign dma_gnt   = (state == ST_DMA) & dma_req;

   // Memory port mux: the core owns the port in every state except DMA.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_we    = ~cpu_rw;
      if (state == ST_DMA) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_we    = dma_req & dma_we;
      end
   end

   // Arbitration FSM, beat counter and DMA read-valid flag.
   // Any visit to CPU lasts at least one cycle by construction, which is
   // what guarantees the core one READY cycle between bursts.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state      <= ST_CPU;
         beat_cnt   <= '0;
         dma_rvalid <= 1'b0;
      end else begin
         dma_rvalid <= dma_gnt & ~dma_we;
         case (state)
            ST_CPU: begin
               if (dma_req) state <= ST_STALL;
            end
            ST_STALL: begin
               if (!dma_req) begin
                  state <= ST_RESUME;
               end else if (cpu_rw) begin
                  state    <= ST_DMA;
                  beat_cnt <= '0;
               end
            end
            ST_DMA: begin
               if (!dma_req) begin
                  state <= ST_RESUME;
               end else begin
                  beat_cnt <= beat_nxt;
                  if (beat_nxt == BURST_LAST) state <= ST_RESUME;
               end
            end
            ST_RESUME: begin
               state <= ST_CPU;
            end
            default: begin
               state <= ST_CPU;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency BRAM model.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 16;

   logic              i_clk;
   logic              i_rst;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_dout;
   logic              cpu_rw;
   logic              cpu_ready;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [7:0]        dma_wdata;
   logic              dma_we;
   logic              dma_gnt;
   logic              dma_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we;
   logic [7:0]        mem_rdata;

   logic [7:0]        bram [0:65535];
   logic              pre_we;
   logic [ADDR_W-1:0] pre_addr;
   logic [7:0]        pre_data;

   int checks;
   int failures;

   mem_arbiter #(.ADDR_W(16), .MAX_BURST(4)) dut (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .cpu_addr   (cpu_addr),
      .cpu_dout   (cpu_dout),
      .cpu_rw     (cpu_rw),
      .cpu_ready  (cpu_ready),
      .dma_req    (dma_req),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_we     (dma_we),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // BRAM model: read-first, 1-cycle read latency, bench preload port.
   always @(posedge i_clk) begin
      mem_rdata <= bram[mem_addr];
      if (pre_we) bram[pre_addr] <= pre_data;
      else if (mem_we) bram[mem_addr] <= mem_wdata;
   end

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      cyc();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      i_rst = 1'b0; cpu_rw = 1'b1; cpu_addr = 16'h0042;
      preload(16'h0010, 8'h77);
      preload(16'h0200, 8'hA5);
      preload(16'h0201, 8'h5A);
      preload(16'h0300, 8'h00);
      #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", cpu_ready); end
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b exp=0", dma_gnt); end
      checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b exp=0", dma_rvalid); end
      checks++; if (mem_addr !== 16'h0042) begin failures++; $display("FAIL rst_addr got=%h exp=0042", mem_addr); end
      cyc();
      i_rst = 1'b1;
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_ready got=%b exp=1", cpu_ready); end
   endtask

   task automatic test_simple_read();
      cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; dma_addr = 16'h0200; dma_we = 1'b0; dma_req = 1'b1; #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL sr_c0_ready got=%b exp=1", cpu_ready); end
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL sr_c0_gnt got=%b exp=0", dma_gnt); end
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL sr_stall_ready got=%b exp=0", cpu_ready); end
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL sr_stall_gnt got=%b exp=0", dma_gnt); end
      cyc(); #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL sr_b1_gnt got=%b exp=1", dma_gnt); end
      checks++; if (mem_addr !== 16'h0200) begin failures++; $display("FAIL sr_b1_addr got=%h exp=0200", mem_addr); end
      cyc(); dma_addr = 16'h0201; #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL sr_b2_gnt got=%b exp=1", dma_gnt); end
      checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL sr_b2_rvalid got=%b exp=1", dma_rvalid); end
      checks++; if (mem_rdata !== 8'hA5) begin failures++; $display("FAIL sr_b1_data got=%h exp=a5", mem_rdata); end
      checks++; if (mem_addr !== 16'h0201) begin failures++; $display("FAIL sr_b2_addr got=%h exp=0201", mem_addr); end
      cyc(); dma_req = 1'b0; dma_we = 1'b1; #1;
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL sr_drop_gnt got=%b exp=0", dma_gnt); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL sr_drop_we got=%b exp=0", mem_we); end
      checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL sr_drop_rvalid got=%b exp=1", dma_rvalid); end
      checks++; if (mem_rdata !== 8'h5A) begin failures++; $display("FAIL sr_b2_data got=%h exp=5a", mem_rdata); end
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL sr_drop_ready got=%b exp=0", cpu_ready); end
      cyc(); dma_we = 1'b0; #1;
      checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL sr_resume_addr got=%h exp=0010", mem_addr); end
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL sr_resume_ready got=%b exp=0", cpu_ready); end
      checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL sr_resume_rvalid got=%b exp=0", dma_rvalid); end
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL sr_cpu_ready got=%b exp=1", cpu_ready); end
      checks++; if (mem_rdata !== 8'h77) begin failures++; $display("FAIL sr_cpu_data got=%h exp=77", mem_rdata); end
   endtask

   task automatic test_write_stall();
      cyc(); cpu_rw = 1'b0; cpu_addr = 16'h01FD; cpu_dout = 8'h11; dma_req = 1'b1; dma_addr = 16'h0200; dma_we = 1'b0; #1;
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ws_w1_we got=%b exp=1", mem_we); end
      cyc(); cpu_addr = 16'h01FC; cpu_dout = 8'h22; #1;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL ws_w2_ready got=%b exp=0", cpu_ready); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ws_w2_we got=%b exp=1", mem_we); end
      checks++; if (mem_addr !== 16'h01FC) begin failures++; $display("FAIL ws_w2_addr got=%h exp=01fc", mem_addr); end
      cyc(); cpu_addr = 16'h01FB; cpu_dout = 8'h33; #1;
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL ws_w3_gnt got=%b exp=0", dma_gnt); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL ws_w3_we got=%b exp=1", mem_we); end
      cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; #1;
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL ws_rd_gnt got=%b exp=0", dma_gnt); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ws_rd_we got=%b exp=0", mem_we); end
      cyc(); #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL ws_grant got=%b exp=1", dma_gnt); end
      cyc(); dma_req = 1'b0;
      cyc();
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL ws_back_ready got=%b exp=1", cpu_ready); end
      checks++; if (bram[16'h01FD] !== 8'h11) begin failures++; $display("FAIL ws_mem_01fd got=%h exp=11", bram[16'h01FD]); end
      checks++; if (bram[16'h01FC] !== 8'h22) begin failures++; $display("FAIL ws_mem_01fc got=%h exp=22", bram[16'h01FC]); end
      checks++; if (bram[16'h01FB] !== 8'h33) begin failures++; $display("FAIL ws_mem_01fb got=%h exp=33", bram[16'h01FB]); end
   endtask

   task automatic test_burst_limit();
      logic [13:0] ready_exp;
      logic [13:0] gnt_exp;
      int          gnts;
      ready_exp = 14'b00000010000001;
      gnt_exp   = 14'b01111000111100;
      gnts      = 0;
      for (int i = 0; i < 14; i++) begin
         cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b0; #1;
         if (dma_gnt === 1'b1) gnts++;
         checks++; if (cpu_ready !== ready_exp[i]) begin failures++; $display("FAIL bl_ready[%0d] got=%b exp=%b", i, cpu_ready, ready_exp[i]); end
         checks++; if (dma_gnt !== gnt_exp[i]) begin failures++; $display("FAIL bl_gnt[%0d] got=%b exp=%b", i, dma_gnt, gnt_exp[i]); end
      end
      checks++; if (gnts !== 8) begin failures++; $display("FAIL bl_count got=%0d exp=8", gnts); end
      cyc(); dma_req = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL bl_end_ready got=%b exp=1", cpu_ready); end
   endtask

   task automatic test_dma_write();
      cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'h3C;
      cyc(); #1;
      cyc(); #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL dw_gnt got=%b exp=1", dma_gnt); end
      checks++; if (mem_we !== 1'b1) begin failures++; $display("FAIL dw_we got=%b exp=1", mem_we); end
      checks++; if (mem_addr !== 16'h0300) begin failures++; $display("FAIL dw_addr got=%h exp=0300", mem_addr); end
      checks++; if (mem_wdata !== 8'h3C) begin failures++; $display("FAIL dw_wdata got=%h exp=3c", mem_wdata); end
      cyc(); dma_we = 1'b0; #1;
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL dw_rd_we got=%b exp=0", mem_we); end
      checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL dw_wr_rvalid got=%b exp=0", dma_rvalid); end
      cyc(); dma_req = 1'b0; #1;
      checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL dw_rd_rvalid got=%b exp=1", dma_rvalid); end
      checks++; if (mem_rdata !== 8'h3C) begin failures++; $display("FAIL dw_rd_data got=%h exp=3c", mem_rdata); end
      checks++; if (bram[16'h0300] !== 8'h3C) begin failures++; $display("FAIL dw_mem got=%h exp=3c", bram[16'h0300]); end
      cyc();
      cyc();
   endtask

   task automatic test_early_drop();
      int gnts;
      cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
      cyc();
      cyc(); #1;
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL ed_gnt got=%b exp=1", dma_gnt); end
      cyc(); dma_req = 1'b0; dma_we = 1'b1; #1;
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL ed_drop_gnt got=%b exp=0", dma_gnt); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ed_drop_we got=%b exp=0", mem_we); end
      checks++; if (mem_addr !== 16'h0200) begin failures++; $display("FAIL ed_drop_addr got=%h exp=0200", mem_addr); end
      cyc(); dma_we = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL ed_resume_ready got=%b exp=0", cpu_ready); end
      checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL ed_resume_addr got=%h exp=0010", mem_addr); end
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL ed_cpu_ready got=%b exp=1", cpu_ready); end
      gnts = 0;
      for (int i = 0; i < 7; i++) begin
         cyc(); dma_req = 1'b1; #1;
         if (dma_gnt === 1'b1) gnts++;
      end
      checks++; if (gnts !== 4) begin failures++; $display("FAIL ed_next_burst got=%0d exp=4", gnts); end
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL ed_next_resume got=%b exp=0", cpu_ready); end
      cyc(); dma_req = 1'b0;
      cyc();
   endtask

   task automatic test_reset_mid_burst();
      cyc(); cpu_rw = 1'b1; cpu_addr = 16'h0010; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h0200;
      cyc();
      cyc();
      cyc(); dma_addr = 16'h0201; #1;
      checks++; if (dma_rvalid !== 1'b1) begin failures++; $display("FAIL rm_pre_rvalid got=%b exp=1", dma_rvalid); end
      checks++; if (dma_gnt !== 1'b1) begin failures++; $display("FAIL rm_pre_gnt got=%b exp=1", dma_gnt); end
      i_rst = 1'b0; #1;
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rm_ready got=%b exp=1", cpu_ready); end
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rm_gnt got=%b exp=0", dma_gnt); end
      checks++; if (dma_rvalid !== 1'b0) begin failures++; $display("FAIL rm_rvalid got=%b exp=0", dma_rvalid); end
      checks++; if (mem_addr !== 16'h0010) begin failures++; $display("FAIL rm_addr got=%h exp=0010", mem_addr); end
      cyc();
      cyc(); i_rst = 1'b1; dma_req = 1'b0; cpu_addr = 16'h0123; #1;
      checks++; if (mem_addr !== 16'h0123) begin failures++; $display("FAIL rm_rel_addr got=%h exp=0123", mem_addr); end
      checks++; if (cpu_ready !== 1'b1) begin failures++; $display("FAIL rm_rel_ready got=%b exp=1", cpu_ready); end
      cyc(); dma_req = 1'b1;
      cyc(); #1;
      checks++; if (cpu_ready !== 1'b0) begin failures++; $display("FAIL rm_restall_ready got=%b exp=0", cpu_ready); end
      checks++; if (dma_gnt !== 1'b0) begin failures++; $display("FAIL rm_restall_gnt got=%b exp=0", dma_gnt); end
      dma_req = 1'b0;
   endtask

   initial begin
      checks = 0; failures = 0;
      i_rst = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_rw = 1'b1;
      dma_req = 1'b0; dma_addr = '0; dma_wdata = '0; dma_we = 1'b0;
      pre_we = 1'b0; pre_addr = '0; pre_data = '0;
      test_reset();
      test_simple_read();
      test_write_stall();
      test_burst_limit();
      test_dma_write();
      test_early_drop();
      test_reset_mid_burst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule
